dmem_responder: RTL

Responder end of the core's MEM-stage load/store port. Accepts one load or store request at a time and serves it from a word-organised SRAM with byte lanes and a configurable number of wait states. Returns sign- or zero-extended load data together with a one-cycle response strobe. While an access is in flight it drives `busy` so the pipeline holds the MEM stage. Misaligned, out-of-range and unsupported accesses complete with an error flag instead of touching the array.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/dmem_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types, funct3 codes and decode helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size from the low funct3 bits; the sign bit does not affect size.
    function automatic size_e size_of(input logic [1:0] f3_lo);
        size_e sz;
        case (f3_lo)
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Stores have no unsigned variants; loads accept all five RV32I codes.
    function automatic logic f3_valid(input logic is_write, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        sext;

    // Replicated store data lets the byte enable alone pick the target lane.
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0;
        rdata_ext  = 32'h0;
        rd_byte    = 8'(rword >> {addr_lo, 3'b000});
        rd_half    = addr_lo[1] ? rword[31:16] : rword[15:0];
        sext       = ~funct3[2];
        case (size_of(funct3[1:0]))
            SZ_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sext & rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sext & rd_half[15]}}, rd_half};
            end
            default: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder: one access at a time, fixed wait states, error on bad requests.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    state_e         state_q, state_nxt;
    logic [CW-1:0]  cnt_q;
    logic           write_q;
    logic [AW-1:0]  idx_q;
    logic [1:0]     lo_q;
    logic [31:0]    wdata_q;
    logic [2:0]     f3_q;

    logic           accept;
    logic           reject;
    logic           misalign;
    logic           out_of_range;

    logic [31:0]    mem [DEPTH_WORDS];
    logic [31:0]    rword;
    logic [3:0]     byte_en;
    logic [31:0]    wdata_lane;
    logic [31:0]    rdata_ext;

    // Request screening on the live inputs, used only at accept time.
    always_comb begin
        misalign = 1'b0;
        case (size_of(req_funct3[1:0]))
            SZ_HALF: misalign = req_addr[0];
            SZ_WORD: misalign = |req_addr[1:0];
            default: misalign = 1'b0;
        endcase
        out_of_range = (req_addr[31:2] >= 30'(DEPTH_WORDS));
        reject       = ~f3_valid(req_write, req_funct3) | misalign | out_of_range;
    end

    // Next-state decode and the combinational stall request.
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    busy   = 1'b1;
                    if (reject) begin
                        state_nxt = ST_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        state_nxt = ST_ACCESS;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (cnt_q <= CW'(1)) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy      = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, wait counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            resp_valid <= (state_nxt == ST_RESP);
            if (accept) begin
                cnt_q <= CW'(WAIT_CYCLES);
            end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (accept && reject) begin
                resp_err   <= 1'b1;
                resp_rdata <= 32'h0;
            end else if (state_q == ST_ACCESS) begin
                resp_err   <= 1'b0;
                resp_rdata <= write_q ? 32'h0 : rdata_ext;
            end
        end
    end

    // Latched copy of the request; the core may change its fields once accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            idx_q   <= '0;
            lo_q    <= 2'b00;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
        end else if (accept) begin
            write_q <= req_write;
            idx_q   <= req_addr[AW+1:2];
            lo_q    <= req_addr[1:0];
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
        end
    end

    dmem_lane_align u_align (
        .addr_lo    (lo_q),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    assign rword = mem[idx_q];

    // Byte-lane array write; contents are deliberately left uninitialised.
    always_ff @(posedge clk) begin
        if ((state_q == ST_ACCESS) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx_q][b*8 +: 8] <= wdata_lane[b*8 +: 8];
                end
            end
        end
    end

endmodule
